stream_demux_reg: RTL and testbench

- Registered 1-to-N stream demultiplexer; the distributing counterpart of the 2:1 mux primitive.
- Accepts one valid/ready input stream tagged with a destination select.
- Holds each accepted word in a single output stage and presents it on exactly one of N_OUT valid/ready output lanes.
- Sits between a single producer and N_OUT consumers; out-of-range selects are dropped and counted.

---
 rtl/stream_demux_reg.sv | 106 ++++++++++
 tb/tb_stream_demux_reg.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_reg.sv
// Registered 1-to-N stream demultiplexer.
// One input stream carries a lane select with each word. An accepted word is
// held in a single output stage and shown on exactly one of N_OUT output
// lanes. Words whose select names a lane that does not exist are discarded.
// Each discarded word raises err_drop for one cycle and bumps a saturating
// counter.
module stream_demux_reg #(
  parameter int N_OUT = 3,
  parameter int W     = 8,
  localparam int SW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [SW-1:0]    in_sel,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [W-1:0]     out_data,
  output logic             err_drop,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  // Lane count widened by one bit, so a select can be compared against it.
  localparam logic [SW:0] N_OUT_W = (SW + 1)'(N_OUT);

  state_t        state_q, state_d;
  logic [W-1:0]  data_q,  data_d;
  logic [SW-1:0] sel_q,   sel_d;
  logic          err_q,   err_d;
  logic [7:0]    cnt_q,   cnt_d;

  logic drain;
  logic accept;
  logic sel_ok;

  // Handshake terms. in_ready depends combinationally on out_ready, so a
  // word can drain and be replaced in the same cycle.
  always_comb begin
    drain    = (state_q == FULL) && out_ready[sel_q];
    in_ready = !rst && ((state_q == EMPTY) || drain);
    accept   = in_valid && in_ready;
    sel_ok   = ({1'b0, in_sel} < N_OUT_W);
  end

  // The outputs come only from registers. When the stage is empty, the lane
  // vector is all zero.
  always_comb begin
    out_valid = (state_q == FULL) ? (N_OUT'(1) << sel_q) : '0;
    out_data  = data_q;
    err_drop  = err_q;
    drop_cnt  = cnt_q;
  end

  // Next-state logic. The stage empties on a drain and refills on a valid
  // accept. A drop only updates the error pulse and the counter.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned. An unassigned path would infer a latch.
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (drain) begin
      state_d = EMPTY;
    end

    if (accept) begin
      if (sel_ok) begin
        state_d = FULL;
        data_d  = in_data;
        sel_d   = in_sel;
      end else begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end
  end

  // State register with synchronous reset. Reset discards any held word.
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments only. Every flop then samples the
    // values from before the edge, whatever order the statements are in.
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_demux_reg.sv
// Self-checking bench for stream_demux_reg with the default parameters
// (3 lanes, 8-bit data). It runs directed scenarios, then a randomized run.
// The randomized run is checked against a transaction-level model: a
// one-entry queue of held words plus a drop tally.
module tb_stream_demux_reg;

  localparam int N_OUT = 3;
  localparam int W     = 8;
  localparam int SW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic [SW-1:0]    in_sel;
  logic [N_OUT-1:0] out_valid;
  logic [N_OUT-1:0] out_ready;
  logic [W-1:0]     out_data;
  logic             err_drop;
  logic [7:0]       drop_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
  } word_t;

  // Reference model: the word being presented (if any), the drop tally, and
  // whether a drop occurred in the last cycle.
  word_t slot[$];
  int    drops;
  bit    err_exp;

  stream_demux_reg #(.N_OUT(N_OUT), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err_drop (err_drop),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic exp_ready();
    if (rst) return 1'b0;
    if (slot.size() == 0) return 1'b1;
    return out_ready[slot[0].sel];
  endfunction

  function automatic logic [N_OUT-1:0] exp_valid();
    if (slot.size() == 0) return '0;
    return N_OUT'(1) << slot[0].sel;
  endfunction

  // Update the model from the inputs applied this cycle, then advance one
  // clock. Inputs change only at the falling edge.
  task automatic tick();
    bit rdy;
    bit drn;
    rdy = exp_ready();
    drn = !rst && slot.size() != 0 && out_ready[slot[0].sel];
    err_exp = 1'b0;
    if (rst) begin
      slot.delete();
      drops = 0;
    end else begin
      if (drn) void'(slot.pop_front());
      if (in_valid && rdy) begin
        if (int'(in_sel) < N_OUT) begin
          slot.push_back('{sel: in_sel, data: in_data});
        end else begin
          err_exp = 1'b1;
          if (drops < 255) drops++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h55; out_ready = '1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 3'b000 || drop_cnt !== 8'd0 || err_drop !== 1'b0 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_state: out_valid=%b drop_cnt=%0d err=%b data=%h want 000/0/0/00",
               out_valid, drop_cnt, err_drop, out_data);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single_route();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 3'b111;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b100 || out_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_route: out_valid=%b data=%h want 100/a5", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_drain: out_valid=%b want 000", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 3'b000; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h11;
    tick();
    in_sel = 2'd0; in_data = 8'h22;  // must not be taken while stalled
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (out_valid !== 3'b010 || out_data !== 8'h11 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: out_valid=%b data=%h in_ready=%b want 010/11/0",
                 i, out_valid, out_data, in_ready);
      end
      tick();
    end
    out_ready = 3'b001;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_wrong_lane_ready: in_ready=%b want 0", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 3'b010 || out_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_wrong_lane_hold: out_valid=%b data=%h want 010/11", out_valid, out_data);
    end
    in_valid = 1'b0; out_ready = 3'b010;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_drain_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL bp_drained: out_valid=%b want 000", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0]    sels [4];
    logic [N_OUT-1:0] hots [4];
    sels = '{2'd0, 2'd1, 2'd2, 2'd0};
    hots = '{3'b001, 3'b010, 3'b100, 3'b001};
    out_ready = 3'b111;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = sels[i]; in_data = 8'(i + 1);
      #1;
      if (i > 0) begin
        tests_run++;
        if (out_valid !== hots[i-1] || out_data !== 8'(i) || in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b[%0d]: out_valid=%b data=%h in_ready=%b want %b/%h/1",
                   i - 1, out_valid, out_data, in_ready, hots[i-1], 8'(i));
        end
      end
      tick();
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b001 || out_data !== 8'h04) begin
      tests_failed++;
      $display("FAIL b2b[3]: out_valid=%b data=%h want 001/04", out_valid, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL b2b_end: out_valid=%b want 000", out_valid);
    end
  endtask

  task automatic test_invalid_select();
    out_ready = 3'b111; in_valid = 1'b1; in_sel = 2'd3; in_data = 8'hFF;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (err_drop !== 1'b1 || drop_cnt !== 8'd1 || out_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL drop_once: err=%b drop_cnt=%0d out_valid=%b want 1/1/000",
               err_drop, drop_cnt, out_valid);
    end
    tick();
    tests_run++;
    if (err_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_pulse_width: err=%b want 0", err_drop);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      tests_run++;
      if (err_drop !== 1'b1 || out_valid !== 3'b000 || drop_cnt !== 8'(drops)) begin
        tests_failed++;
        $display("FAIL drop_run[%0d]: err=%b out_valid=%b drop_cnt=%0d want 1/000/%0d",
                 i, err_drop, out_valid, drop_cnt, drops);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (drop_cnt !== 8'd255 || err_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_saturate: drop_cnt=%0d err=%b want 255/0", drop_cnt, err_drop);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 3'b000; in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 3'b001) begin
      tests_failed++;
      $display("FAIL midrst_full: out_valid=%b want 001", out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 3'b000 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL midrst_cleared: out_valid=%b drop_cnt=%0d want 000/0", out_valid, drop_cnt);
    end
    out_ready = 3'b111;
    tick();
    tests_run++;
    if (out_valid !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_lost: out_valid=%b want 000", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sel    = SW'($urandom_range(0, 3));
      in_data   = W'($urandom);
      out_ready = N_OUT'($urandom);
      #1;
      tests_run++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid() ||
          (slot.size() != 0 && out_data !== slot[0].data) ||
          err_drop !== err_exp || drop_cnt !== 8'(drops)) begin
        tests_failed++;
        $display("FAIL random[%0d]: rdy=%b vld=%b data=%h err=%b cnt=%0d want %b/%b/%h/%b/%0d",
                 i, in_ready, out_valid, out_data, err_drop, drop_cnt,
                 exp_ready(), exp_valid(), (slot.size() != 0) ? slot[0].data : out_data,
                 err_exp, drops);
      end
      tick();
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    drops = 0;
    err_exp = 1'b0;
    test_reset();
    test_single_route();
    test_backpressure();
    test_back_to_back();
    test_invalid_select();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
